// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the three-bank APB memory target.
// Phase FSM encoding, slave one-hot selects and counter widths.
package apb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  localparam logic [2:0] SEL0 = 3'b001;
  localparam logic [2:0] SEL1 = 3'b010;
  localparam logic [2:0] SEL2 = 3'b100;

  localparam int ERR_CNT_W  = 8;
  localparam int XFER_CNT_W = 16;

  function automatic logic is_onehot3(logic [2:0] s);
    return (s != 3'd0) && ((s & (s - 3'd1)) == 3'd0);
  endfunction

endpackage

// File: rtl/apb_mem_bank.sv
// DEPTH x 32 word bank: one synchronous write port,
// one combinational read port, synchronous clear.
module apb_mem_bank #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave_mem.sv
// Three-bank APB memory target with phase tracking,
// protocol-violation flagging and transfer counters.
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int ADDR_LSB = 2
) (
  input  logic                  Hclk,
  input  logic                  Hreset,
  input  logic                  Pwrite,
  input  logic                  Penable,
  input  logic [2:0]            Pselx,
  input  logic [31:0]           Paddr,
  input  logic [31:0]           Pwdata,
  output logic [31:0]           Prdata,
  output logic                  prot_err,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [XFER_CNT_W-1:0] wr_count,
  output logic [XFER_CNT_W-1:0] rd_count
);

  localparam int IDX_W = $clog2(DEPTH);

  state_e                  state_q, state_d;
  logic [2:0]              sel_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    wr_q;
  logic [31:0]             rdata_q;
  logic                    perr_q;
  logic [ERR_CNT_W-1:0]    err_cnt_q;
  logic [XFER_CNT_W-1:0]   wr_cnt_q, rd_cnt_q;

  logic [IDX_W-1:0] idx;
  logic             sel_ok, sel_bad, setup, access, match;
  logic             latch, viol, commit;
  logic [31:0]      bank_rd [3];
  logic [31:0]      rd_mux;
  logic             unused_paddr;

  assign idx     = Paddr[ADDR_LSB +: IDX_W];
  assign sel_ok  = is_onehot3(Pselx);
  assign sel_bad = (Pselx != 3'd0) && !sel_ok;
  assign setup   = sel_ok && !Penable;
  assign access  = sel_ok && Penable;
  assign match   = (Pselx == sel_q) && (idx == idx_q)
                && (Pwrite == wr_q);

  assign unused_paddr = ^{Paddr[31:ADDR_LSB+IDX_W],
                          Paddr[ADDR_LSB-1:0]};

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    viol    = 1'b0;
    commit  = 1'b0;
    if (sel_bad) begin
      viol    = 1'b1;
      state_d = IDLE;
    end else if (Pselx == 3'd0) begin
      viol    = (state_q == SETUP);
      state_d = IDLE;
    end else if (setup) begin
      // A second setup edge is a stall: flagged, but relatched.
      latch   = 1'b1;
      viol    = (state_q == SETUP);
      state_d = SETUP;
    end else if (access && state_q == SETUP && match) begin
      commit  = 1'b1;
      state_d = ACCESS;
    end else begin
      viol    = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        sel_q <= Pselx;
        idx_q <= idx;
        wr_q  <= Pwrite;
      end
    end
  end

  for (genvar b = 0; b < 3; b++) begin : g_bank
    apb_mem_bank #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
    ) u_bank (
      .clk_i   (Hclk),
      .clr_i   (Hreset),
      .we_i    (commit && wr_q && sel_q[b]),
      .waddr_i (idx_q),
      .wdata_i (Pwdata),
      .raddr_i (idx),
      .rdata_o (bank_rd[b])
    );
  end

  always_comb begin
    rd_mux = '0;
    case (Pselx)
      SEL0:    rd_mux = bank_rd[0];
      SEL1:    rd_mux = bank_rd[1];
      SEL2:    rd_mux = bank_rd[2];
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      rdata_q   <= '0;
      perr_q    <= 1'b0;
      err_cnt_q <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      if (latch && !Pwrite) begin
        rdata_q <= rd_mux;
      end
      if (viol) begin
        perr_q <= 1'b1;
        if (err_cnt_q != '1) begin
          err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
      end
      if (commit && wr_q) begin
        wr_cnt_q <= wr_cnt_q + XFER_CNT_W'(1);
      end
      if (commit && !wr_q) begin
        rd_cnt_q <= rd_cnt_q + XFER_CNT_W'(1);
      end
    end
  end

  assign Prdata    = rdata_q;
  assign prot_err  = perr_q;
  assign err_count = err_cnt_q;
  assign wr_count  = wr_cnt_q;
  assign rd_count  = rd_cnt_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: transfers, aliasing,
// violations, saturation/wrap and mid-transfer reset.
module tb_apb_slave_mem;

  logic        Hclk = 1'b0;
  logic        Hreset = 1'b1;
  logic        Pwrite = 1'b0;
  logic        Penable = 1'b0;
  logic [2:0]  Pselx = 3'd0;
  logic [31:0] Paddr = '0;
  logic [31:0] Pwdata = '0;
  logic [31:0] Prdata;
  logic        prot_err;
  logic [7:0]  err_count;
  logic [15:0] wr_count;
  logic [15:0] rd_count;

  int errors = 0;
  int checks = 0;

  apb_slave_mem #(.DEPTH(16), .ADDR_LSB(2)) dut (
    .Hclk      (Hclk),
    .Hreset    (Hreset),
    .Pwrite    (Pwrite),
    .Penable   (Penable),
    .Pselx     (Pselx),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata),
    .Prdata    (Prdata),
    .prot_err  (prot_err),
    .err_count (err_count),
    .wr_count  (wr_count),
    .rd_count  (rd_count)
  );

  always #5 Hclk = ~Hclk;

  // Inputs change on the falling edge; one call spans one rising edge.
  task automatic cyc(input logic [2:0] s, input logic en,
                     input logic wr, input logic [31:0] a,
                     input logic [31:0] d);
    @(negedge Hclk);
    Pselx = s; Penable = en; Pwrite = wr; Paddr = a; Pwdata = d;
  endtask

  task automatic idle();
    cyc(3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge Hclk);
    Hreset = 1'b1;
    Pselx = 3'd0; Penable = 1'b0; Pwrite = 1'b0;
    Paddr = '0; Pwdata = '0;
    repeat (2) @(negedge Hclk);
    Hreset = 1'b0;
  endtask

  task automatic apb_write(input logic [2:0] s, input logic [31:0] a,
                           input logic [31:0] d);
    cyc(s, 1'b0, 1'b1, a, d);
    cyc(s, 1'b1, 1'b1, a, d);
  endtask

  // Returns Prdata as seen during the access cycle.
  task automatic apb_read(input logic [2:0] s, input logic [31:0] a,
                          output logic [31:0] d);
    cyc(s, 1'b0, 1'b0, a, 32'd0);
    cyc(s, 1'b1, 1'b0, a, 32'd0);
    d = Prdata;
  endtask

  task automatic test_reset();
    do_reset();
    idle();
    checks++;
    if (Prdata !== 32'd0) begin
      errors++; $display("FAIL reset_prdata got=%h exp=0", Prdata);
    end
    checks++;
    if (prot_err !== 1'b0) begin
      errors++; $display("FAIL reset_prot got=%b exp=0", prot_err);
    end
    checks++;
    if (err_count !== 8'd0) begin
      errors++; $display("FAIL reset_err got=%0d exp=0", err_count);
    end
    checks++;
    if (wr_count !== 16'd0) begin
      errors++; $display("FAIL reset_wr got=%0d exp=0", wr_count);
    end
    checks++;
    if (rd_count !== 16'd0) begin
      errors++; $display("FAIL reset_rd got=%0d exp=0", rd_count);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    do_reset();
    apb_write(3'b010, 32'h8, 32'hDEADBEEF);
    apb_read(3'b010, 32'h8, d);
    idle();
    checks++;
    if (d !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_rd got=%h exp=deadbeef", d);
    end
    checks++;
    if (wr_count !== 16'd1) begin
      errors++; $display("FAIL basic_wr got=%0d exp=1", wr_count);
    end
    checks++;
    if (rd_count !== 16'd1) begin
      errors++; $display("FAIL basic_rdcnt got=%0d exp=1", rd_count);
    end
    checks++;
    if (prot_err !== 1'b0) begin
      errors++; $display("FAIL basic_prot got=%b exp=0", prot_err);
    end
    // Bank0 at the same index must be untouched.
    apb_read(3'b001, 32'h8, d);
    idle();
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL basic_bank0 got=%h exp=0", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 4; i++)
      apb_write(3'b001, 32'(i * 4), 32'(i + 1));
    for (int i = 0; i < 4; i++) begin
      apb_read(3'b001, 32'(i * 4), d);
      checks++;
      if (d !== 32'(i + 1)) begin
        errors++; $display("FAIL b2b_rd%0d got=%h exp=%h", i, d, i + 1);
      end
    end
    idle();
    checks++;
    if (wr_count !== 16'd4) begin
      errors++; $display("FAIL b2b_wr got=%0d exp=4", wr_count);
    end
    checks++;
    if (rd_count !== 16'd4) begin
      errors++; $display("FAIL b2b_rdcnt got=%0d exp=4", rd_count);
    end
    // Write then immediately read the same word with no idle.
    apb_write(3'b100, 32'h14, 32'hCAFE0001);
    apb_read(3'b100, 32'h14, d);
    idle();
    checks++;
    if (d !== 32'hCAFE0001) begin
      errors++; $display("FAIL b2b_wr_rd got=%h exp=cafe0001", d);
    end
  endtask

  task automatic test_alias();
    logic [31:0] d;
    do_reset();
    apb_write(3'b100, 32'h40, 32'h55);
    apb_read(3'b100, 32'h0, d);
    idle();
    checks++;
    if (d !== 32'h55) begin
      errors++; $display("FAIL alias_rd got=%h exp=55", d);
    end
  endtask

  task automatic test_violations();
    logic [31:0] d;
    do_reset();
    apb_write(3'b001, 32'h4, 32'hA5);
    idle();
    cyc(3'b001, 1'b1, 1'b1, 32'h4, 32'h77);
    idle();
    checks++;
    if (prot_err !== 1'b1 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL viol_idle_acc got=%b/%0d exp=1/1", prot_err, err_count);
    end
    cyc(3'b011, 1'b0, 1'b1, 32'h4, 32'h77);
    idle();
    checks++;
    if (err_count !== 8'd2) begin
      errors++; $display("FAIL viol_sel got=%0d exp=2", err_count);
    end
    cyc(3'b001, 1'b0, 1'b1, 32'h4, 32'h111);
    cyc(3'b001, 1'b1, 1'b1, 32'h8, 32'h111);
    idle();
    checks++;
    if (err_count !== 8'd3) begin
      errors++; $display("FAIL viol_addr got=%0d exp=3", err_count);
    end
    checks++;
    if (wr_count !== 16'd1) begin
      errors++; $display("FAIL viol_wr got=%0d exp=1", wr_count);
    end
    apb_read(3'b001, 32'h4, d);
    checks++;
    if (d !== 32'hA5) begin
      errors++; $display("FAIL viol_mem4 got=%h exp=a5", d);
    end
    apb_read(3'b001, 32'h8, d);
    idle();
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL viol_mem8 got=%h exp=0", d);
    end
    // Stall: two setups then access; only the stall edge is flagged.
    cyc(3'b010, 1'b0, 1'b1, 32'h0, 32'h9);
    cyc(3'b010, 1'b0, 1'b1, 32'h0, 32'h9);
    cyc(3'b010, 1'b1, 1'b1, 32'h0, 32'h9);
    idle();
    checks++;
    if (err_count !== 8'd4 || wr_count !== 16'd2) begin
      errors++;
      $display("FAIL viol_stall got=%0d/%0d exp=4/2", err_count, wr_count);
    end
    checks++;
    if (prot_err !== 1'b1) begin
      errors++; $display("FAIL viol_sticky got=%b exp=1", prot_err);
    end
  endtask

  task automatic test_sat_wrap();
    do_reset();
    for (int i = 0; i < 300; i++)
      cyc(3'b110, 1'b0, 1'b0, 32'd0, 32'd0);
    idle();
    checks++;
    if (err_count !== 8'd255) begin
      errors++; $display("FAIL sat_err got=%0d exp=255", err_count);
    end
    @(negedge Hclk);
    force dut.wr_cnt_q = 16'hFFFF;
    #1 release dut.wr_cnt_q;
    apb_write(3'b001, 32'h0, 32'h1);
    idle();
    checks++;
    if (wr_count !== 16'd0) begin
      errors++; $display("FAIL wrap_wr got=%0d exp=0", wr_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    do_reset();
    apb_write(3'b001, 32'h8, 32'h3);
    idle();
    cyc(3'b001, 1'b0, 1'b1, 32'hC, 32'h1234);
    @(negedge Hclk);
    Hreset = 1'b1; Penable = 1'b1;
    @(negedge Hclk);
    Hreset = 1'b0;
    Pselx = 3'd0; Penable = 1'b0; Pwrite = 1'b0;
    idle();
    checks++;
    if (Prdata !== 32'd0 || prot_err !== 1'b0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL rstmid_out got=%h/%b/%0d exp=0/0/0",
               Prdata, prot_err, err_count);
    end
    checks++;
    if (wr_count !== 16'd0 || rd_count !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_cnt got=%0d/%0d exp=0/0", wr_count, rd_count);
    end
    apb_read(3'b001, 32'hC, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL rstmid_idx3 got=%h exp=0", d);
    end
    apb_read(3'b001, 32'h8, d);
    idle();
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL rstmid_clr got=%h exp=0", d);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_alias();
    test_violations();
    test_sat_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
